// File: rtl/sram_1mx8_ctrl_pkg.sv
// sram_1mx8_ctrl_pkg: shared widths, state encoding and wait-counter sizing
// for the external 1Mx8 asynchronous SRAM sequencer.
package sram_1mx8_ctrl_pkg;

    localparam int SRAM_AW = 20;
    localparam int SRAM_DW = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_TURN
    } state_t;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sram_1mx8_ctrl.sv
// sram_1mx8_ctrl: single-byte read/write sequencer for a 1Mx8 async SRAM with
// parameterised wait states; every output is registered off the state transition.
module sram_1mx8_ctrl
    import sram_1mx8_ctrl_pkg::*;
#(
    parameter int RD_WAIT  = 2,
    parameter int WR_PULSE = 2,
    parameter int TURN_CYC = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic               i_req_we,
    input  logic [SRAM_AW-1:0] i_req_addr,
    input  logic [SRAM_DW-1:0] i_req_wdata,
    output logic               o_rsp_valid,
    output logic [SRAM_DW-1:0] o_rsp_rdata,
    output logic               o_busy,
    output logic [SRAM_AW-1:0] o_sram_addr,
    output logic               o_sram_ce_n,
    output logic               o_sram_oe_n,
    output logic               o_sram_we_n,
    output logic [SRAM_DW-1:0] o_sram_dq,
    output logic               o_sram_dq_oe,
    input  logic [SRAM_DW-1:0] i_sram_dq
);

    localparam int CW = cnt_width(RD_WAIT, WR_PULSE, TURN_CYC);
    localparam logic [CW-1:0] RD_LD = CW'(RD_WAIT - 1);
    localparam logic [CW-1:0] WR_LD = CW'(WR_PULSE - 1);
    localparam logic [CW-1:0] TN_LD = CW'(TURN_CYC - 1);

    state_t state;
    logic [CW-1:0] cnt;

    // One down-counter, loaded with N-1 on entry, serves RD, WR_PULSE and TURN.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            o_req_ready  <= 1'b0;
            o_rsp_valid  <= 1'b0;
            o_rsp_rdata  <= '0;
            o_busy       <= 1'b0;
            o_sram_addr  <= '0;
            o_sram_ce_n  <= 1'b1;
            o_sram_oe_n  <= 1'b1;
            o_sram_we_n  <= 1'b1;
            o_sram_dq    <= '0;
            o_sram_dq_oe <= 1'b0;
        end else begin
            o_rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_req_valid && o_req_ready) begin
                        o_req_ready <= 1'b0;
                        o_busy      <= 1'b1;
                        o_sram_addr <= i_req_addr;
                        o_sram_dq   <= i_req_wdata;
                        o_sram_ce_n <= 1'b0;
                        if (i_req_we) begin
                            state        <= ST_WR_SETUP;
                            o_sram_dq_oe <= 1'b1;
                        end else begin
                            state       <= ST_RD;
                            o_sram_oe_n <= 1'b0;
                            cnt         <= RD_LD;
                        end
                    end else begin
                        o_req_ready <= 1'b1;
                    end
                end
                ST_RD: begin
                    if (cnt == '0) begin
                        o_rsp_rdata <= i_sram_dq;
                        o_rsp_valid <= 1'b1;
                        o_sram_ce_n <= 1'b1;
                        o_sram_oe_n <= 1'b1;
                        if (TURN_CYC == 0) begin
                            state       <= ST_IDLE;
                            o_req_ready <= 1'b1;
                            o_busy      <= 1'b0;
                        end else begin
                            state <= ST_TURN;
                            cnt   <= TN_LD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_TURN: begin
                    if (cnt == '0) begin
                        state       <= ST_IDLE;
                        o_req_ready <= 1'b1;
                        o_busy      <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WR_SETUP: begin
                    state       <= ST_WR_PULSE;
                    o_sram_we_n <= 1'b0;
                    cnt         <= WR_LD;
                end
                ST_WR_PULSE: begin
                    if (cnt == '0) begin
                        state       <= ST_WR_HOLD;
                        o_sram_we_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WR_HOLD: begin
                    state        <= ST_IDLE;
                    o_sram_ce_n  <= 1'b1;
                    o_sram_dq_oe <= 1'b0;
                    o_rsp_valid  <= 1'b1;
                    o_req_ready  <= 1'b1;
                    o_busy       <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_1mx8_ctrl.sv
// tb_sram_1mx8_ctrl: two controllers (default and minimum wait states) against
// async SRAM models with strobe-ordering checks and a byte-array scoreboard.
module tb_sram_1mx8_ctrl;

    logic        i_clk = 1'b0;
    logic        rst_n     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [19:0] req_addr  [2];
    logic [7:0]  req_wdata [2];
    logic        rsp_valid [2];
    logic [7:0]  rsp_rdata [2];
    logic        busy      [2];
    logic [19:0] sram_addr [2];
    logic        sram_ce_n [2];
    logic        sram_oe_n [2];
    logic        sram_we_n [2];
    logic [7:0]  sram_dq   [2];
    logic        sram_dq_oe[2];

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_mem [logic [20:0]];

    always #5 i_clk = ~i_clk;

    function automatic int rdw(input int k); return (k == 0) ? 2 : 1; endfunction
    function automatic int wrp(input int k); return (k == 0) ? 2 : 1; endfunction
    function automatic int trn(input int k); return (k == 0) ? 1 : 0; endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0]  rd;
        logic [7:0]  mem [logic [19:0]];
        logic        p_ce = 1'b1, p_oe = 1'b1, p_we = 1'b1, p_rsp = 1'b0;
        logic [19:0] p_addr = '0;
        logic [7:0]  p_dq = '0;

        sram_1mx8_ctrl #(
            .RD_WAIT (g == 0 ? 2 : 1),
            .WR_PULSE(g == 0 ? 2 : 1),
            .TURN_CYC(g == 0 ? 1 : 0)
        ) u_dut (
            .i_clk       (i_clk),
            .i_rst_n     (rst_n[g]),
            .i_req_valid (req_valid[g]),
            .o_req_ready (req_ready[g]),
            .i_req_we    (req_we[g]),
            .i_req_addr  (req_addr[g]),
            .i_req_wdata (req_wdata[g]),
            .o_rsp_valid (rsp_valid[g]),
            .o_rsp_rdata (rsp_rdata[g]),
            .o_busy      (busy[g]),
            .o_sram_addr (sram_addr[g]),
            .o_sram_ce_n (sram_ce_n[g]),
            .o_sram_oe_n (sram_oe_n[g]),
            .o_sram_we_n (sram_we_n[g]),
            .o_sram_dq   (sram_dq[g]),
            .o_sram_dq_oe(sram_dq_oe[g]),
            .i_sram_dq   (rd)
        );

        // Async SRAM: byte lands on the WE# rising edge; DQ only valid with CE#/OE# low.
        always @(negedge i_clk) begin
            if (!p_we && sram_we_n[g] && !p_ce) mem[p_addr] = p_dq;
            chk("dq_oe_needs_oe_high", {31'b0, sram_dq_oe[g] && !(sram_oe_n[g] && p_oe)}, 0);
            chk("we_needs_oe_high_ce_low", {31'b0, !sram_we_n[g] && !(sram_oe_n[g] && p_oe && !sram_ce_n[g])}, 0);
            chk("addr_dq_stable", {31'b0, !p_ce && !sram_ce_n[g] && (sram_addr[g] != p_addr || sram_dq[g] != p_dq)}, 0);
            chk("rsp_single_pulse", {31'b0, rsp_valid[g] && p_rsp}, 0);
            rd = (!sram_ce_n[g] && !sram_oe_n[g] && sram_we_n[g]) ?
                 (mem.exists(sram_addr[g]) ? mem[sram_addr[g]] : 8'h00) : 8'hEE;
            p_ce   = sram_ce_n[g];
            p_oe   = sram_oe_n[g];
            p_we   = sram_we_n[g];
            p_rsp  = rsp_valid[g];
            p_addr = sram_addr[g];
            p_dq   = sram_dq[g];
        end
    end

    task automatic run_op(input int k, input bit we, input logic [19:0] a, input logic [7:0] d);
        int n;
        int lat;
        logic [20:0] key;
        key = {k[0], a};
        req_we[k]    = we;
        req_addr[k]  = a;
        req_wdata[k] = d;
        req_valid[k] = 1'b1;
        n = 0;
        while (!req_ready[k] && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        chk("accept_timeout", {31'b0, n < 100}, 1);
        @(posedge i_clk);
        #1 req_valid[k] = 1'b0;
        if (we) exp_mem[key] = d;
        lat = 0;
        do begin
            @(negedge i_clk);
            lat++;
            if (lat == 1) chk("busy_ready_c1", {30'b0, busy[k], req_ready[k]}, 2);
        end while (!rsp_valid[k] && lat < 50);
        if (we) begin
            chk("wr_latency", lat, wrp(k) + 3);
            chk("wr_ready_with_rsp", {31'b0, req_ready[k]}, 1);
        end else begin
            chk("rd_latency", lat, rdw(k) + 1);
            chk("rd_data", {24'b0, rsp_rdata[k]}, {24'b0, exp_mem.exists(key) ? exp_mem[key] : 8'h00});
            n = 0;
            while (!req_ready[k] && n < 20) begin
                @(negedge i_clk);
                n++;
            end
            chk("rd_to_ready", lat + n, rdw(k) + trn(k) + 1);
        end
    endtask

    initial begin
        logic [19:0] ga;
        int n;
        for (int k = 0; k < 2; k++) begin
            rst_n[k]     = 1'b0;
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_addr[k]  = '0;
            req_wdata[k] = '0;
        end
        repeat (3) @(negedge i_clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_strobes", {28'b0, sram_ce_n[k], sram_oe_n[k], sram_we_n[k], sram_dq_oe[k]}, 4'b1110);
            chk("rst_ready_busy_rsp", {29'b0, req_ready[k], busy[k], rsp_valid[k]}, 0);
            chk("rst_addr_dq_rdata", {4'b0, sram_addr[k], sram_dq[k] | rsp_rdata[k]}, 0);
            rst_n[k] = 1'b1;
        end
        @(negedge i_clk);
        for (int k = 0; k < 2; k++) chk("ready_after_release", {31'b0, req_ready[k]}, 1);

        // reset held 3 cycles while idle
        rst_n[0] = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            chk("idle_rst_outputs", {27'b0, req_ready[0], sram_ce_n[0], sram_oe_n[0], sram_we_n[0], sram_dq_oe[0]}, 5'b01110);
        end
        rst_n[0] = 1'b1;
        @(negedge i_clk);
        chk("idle_rst_release_ready", {31'b0, req_ready[0]}, 1);

        run_op(0, 1'b1, 20'h12345, 8'hA5);
        run_op(0, 1'b0, 20'h12345, 8'h00);
        run_op(0, 1'b0, 20'hFFFFF, 8'h00);
        run_op(0, 1'b1, 20'h00000, 8'h3C);
        run_op(0, 1'b0, 20'h00000, 8'h00);

        // valid held through busy with a changing address
        req_we[0] = 1'b1; req_addr[0] = 20'h00100; req_wdata[0] = 8'h5A; req_valid[0] = 1'b1;
        n = 0;
        while (!req_ready[0] && n < 100) begin @(negedge i_clk); n++; end
        @(posedge i_clk);
        #1 exp_mem[{1'b0, 20'h00100}] = 8'h5A;
        ga = 20'h50000;
        @(negedge i_clk);
        n = 0;
        while (!req_ready[0] && n < 50) begin
            ga = {4'h5, 16'($urandom)};
            req_addr[0] = ga;
            req_wdata[0] = 8'($urandom);
            @(negedge i_clk);
            n++;
        end
        chk("hold_ready_timeout", {31'b0, n < 50}, 1);
        run_op(0, 1'b0, 20'h00100, 8'h00);
        run_op(0, 1'b0, ga, 8'h00);

        // reset in the second WE# low cycle aborts the write
        req_we[0] = 1'b1; req_addr[0] = 20'h77777; req_wdata[0] = 8'hC3; req_valid[0] = 1'b1;
        n = 0;
        while (!req_ready[0] && n < 100) begin @(negedge i_clk); n++; end
        @(posedge i_clk);
        #1 req_valid[0] = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("abort_we_low", {31'b0, sram_we_n[0]}, 0);
        rst_n[0] = 1'b0;
        @(negedge i_clk);
        chk("abort_outputs", {27'b0, sram_ce_n[0], sram_oe_n[0], sram_we_n[0], sram_dq_oe[0], rsp_valid[0]}, 5'b11100);
        repeat (2) begin
            @(negedge i_clk);
            chk("abort_no_rsp", {31'b0, rsp_valid[0]}, 0);
        end
        rst_n[0] = 1'b1;
        @(negedge i_clk);
        chk("abort_release", {30'b0, req_ready[0], rsp_valid[0]}, 2'b10);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 256; i++) begin
                logic [19:0] a;
                a = ($urandom_range(0, 1) != 0 ? 20'hFFFC0 : 20'h00000) | 20'($urandom_range(0, 63));
                run_op(k, 1'($urandom_range(0, 1)), a, 8'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
